sic_dispatcher: RTL
===================

// Module: sic_dispatcher
// PURPOSE
//  Hands renamed instruction packets, in order, to the single-instruction controllers (SICs).
//  Sits between the rename stage and the SIC array. Stamps each packet with a monotonically wrapping issue_id.
//  Holds each offer until one SIC latches it. Stalls issue behind a JR until that SIC reports its PC redirect, then forwards the redirect to fetch.
// PARAMETERS
//  NUM_SIC     4  number of SICs served (>=2)
//  ID_WIDTH    8  issue_id width; counter wraps mod 2**ID_WIDTH
//  FIFO_DEPTH  4  inbound packet buffer entries (power of 2, >=2)
// PORTS
//  clk                   in   1                 clock
//  rst_n                 in   1                 reset, asynchronous, active-low
//  in_valid              in   1                 rename stage offers in_pkt
//  in_ready              out  1                 FIFO not full (combinational from occupancy)
//  in_pkt                in   sic_packet_t      renamed packet; incoming issue_id field ignored
//  sic_req_instr         in   NUM_SIC           per-SIC request for an instruction
//  sic_packet_out        out  sic_packet_t[NUM_SIC]  per-SIC packet; only .valid of non-target SICs is 0
//  sic_redirect_valid    in   NUM_SIC           per-SIC JR commit pulse
//  sic_redirect_pc       in   32*NUM_SIC        per-SIC JR target
//  sic_redirect_issue_id in   ID_WIDTH*NUM_SIC  per-SIC JR issue_id
//  fetch_redirect_valid  out  1                 1-cycle pulse to fetch: restart at fetch_redirect_pc
//  fetch_redirect_pc     out  32                redirect target
//  jr_stall              out  1                 high while waiting on a JR redirect
// BEHAVIOUR
//  Reset: FIFO empty, issue_id counter 0, rr pointer 0, state IDLE, all sic_packet_out.valid 0,
//   fetch_redirect_valid 0, fetch_redirect_pc 0, jr_stall 0. Reset mid-offer drops the offer.
//  FIFO: push when in_valid && in_ready. Pop only on offer creation. Simultaneous push+pop when full is not allowed (in_ready=0).
//  FSM IDLE -> OFFER -> (IDLE | WAIT_JR):
//   IDLE: if FIFO non-empty and any sic_req_instr: target = first requesting SIC at or after rr pointer (round-robin).
//    Register packet with issue_id=counter and valid=1 into sic_packet_out[target]. Pop FIFO. counter++ (wraps). Go to OFFER.
//   OFFER: hold packet unchanged. Accept = target's valid && !sic_req_instr[target] in the same cycle.
//    An IDLE SIC still shows req=1 and does not latch, so the offer is held.
//    On accept: clear valid next edge; rr pointer = target+1 mod NUM_SIC.
//    If the accepted packet is JR (opcode SPECIAL, funct 6'h08), go to WAIT_JR; otherwise go to IDLE.
//    Throughput: at most one packet per 2 cycles.
//   WAIT_JR: jr_stall=1; no offers. On any sic_redirect_valid[k] whose issue_id == stored JR id:
//    fetch_redirect_valid=1 next cycle with that pc. Flush FIFO (wrong-path) on the same edge. Go to IDLE.
//    Redirects with a non-matching id are ignored. If several match in one cycle, the lowest k wins.
//  A push arriving in the same cycle as the flush is dropped. in_ready is 0 in WAIT_JR.
//  Only one offer is outstanding at any time, so packets are handed over strictly in issue_id order.
// STRUCTURE
//  sic_packet_t, OPC_SPECIAL, and a new FUNCT_JR=6'h08 constant live in the shared structs.svh package.
//  Sub-module pkt_fifo (parameterised sync FIFO with flush) holds the inbound buffer.
//  Round-robin select and FSM stay in this module.
// TESTING
//  1. 3 packets, all SICs IDLE->WAIT: issue_ids 0,1,2 go to SIC0,1,2; each offer lasts 1 cycle.
//  2. Target SIC in IDLE at offer time (req=1 for 1 cycle): offer is held 2 cycles and accepted once; no duplicate issue.
//  3. JR (id 5) accepted, followed by 2 FIFO packets: jr_stall=1, no offers.
//     Redirect with id 4 ignored; id 5 with pc 0x0040_0100 -> fetch_redirect pulse with that pc, FIFO empty, in_ready=1.
//  4. Counter at 8'hFF: next packets get ids FF, 00.
//  5. FIFO full (4 entries, no SIC requesting): in_ready=0, 5th packet held upstream, not lost; order is preserved on drain.
//  6. Assert rst_n during OFFER: all valid outputs 0 asynchronously; after release, counter restarts at 0.

Source files
------------

// File: rtl/sic_dispatcher_pkg.sv
// Shared types and constants for the SIC dispatcher: packet layout,
// opcode/funct encodings used to detect JR, and the dispatcher FSM states.
package sic_dispatcher_pkg;

    localparam int SIC_ID_WIDTH = 8;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] FUNCT_JR    = 6'h08;

    typedef struct packed {
        logic                    valid;
        logic [5:0]              opcode;
        logic [4:0]              rs;
        logic [4:0]              rt;
        logic [4:0]              rd;
        logic [5:0]              funct;
        logic [15:0]             imm;
        logic [31:0]             pc;
        logic [SIC_ID_WIDTH-1:0] issue_id;
    } sic_packet_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_WAIT_JR
    } disp_state_t;

    function automatic logic is_jr(input sic_packet_t p);
        return (p.opcode == OPC_SPECIAL) && (p.funct == FUNCT_JR);
    endfunction

endpackage

// File: rtl/sic_dispatcher_fifo.sv
// Inbound packet buffer: synchronous FIFO with a flush that empties it in one
// edge. A push in the flush cycle is dropped; push when full and pop when
// empty are ignored.
module pkt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    input  logic             flush,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Pointer update; flush resets both so stale entries become unreachable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sic_dispatcher.sv
// Dispatcher between rename and the SIC array. Buffers renamed packets,
// stamps each with a wrapping issue_id and offers one at a time to a
// round-robin-selected requesting SIC. After a JR is handed over, issue
// stalls until that JR's redirect arrives; the redirect goes to fetch and
// the (wrong-path) buffer is flushed.
module sic_dispatcher
    import sic_dispatcher_pkg::*;
#(
    parameter int NUM_SIC    = 4,
    parameter int ID_WIDTH   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  sic_packet_t                   in_pkt,
    input  logic [NUM_SIC-1:0]            sic_req_instr,
    output sic_packet_t [NUM_SIC-1:0]     sic_packet_out,
    input  logic [NUM_SIC-1:0]            sic_redirect_valid,
    input  logic [32*NUM_SIC-1:0]         sic_redirect_pc,
    input  logic [ID_WIDTH*NUM_SIC-1:0]   sic_redirect_issue_id,
    output logic                          fetch_redirect_valid,
    output logic [31:0]                   fetch_redirect_pc,
    output logic                          jr_stall
);

    localparam int SW = $clog2(NUM_SIC);
    localparam int PW = $bits(sic_packet_t);

    disp_state_t               state, state_d;
    logic [SW-1:0]             tgt, tgt_d;
    logic [SW-1:0]             rr, rr_d;
    logic [ID_WIDTH-1:0]       cnt, cnt_d;
    logic [ID_WIDTH-1:0]       offer_id, offer_id_d;
    sic_packet_t [NUM_SIC-1:0] pkt_q, pkt_d;
    logic                      fr_valid, fr_valid_d;
    logic [31:0]               fr_pc, fr_pc_d;

    logic                      fifo_full;
    logic                      fifo_empty;
    logic [PW-1:0]             fifo_dout;
    sic_packet_t               head;
    logic                      push;
    logic                      pop;
    logic                      flush;

    logic                      req_found;
    logic [SW-1:0]             req_sel;
    int                        idx;
    logic                      rd_match;
    logic [31:0]               rd_pc;

    assign in_ready             = !fifo_full && (state != ST_WAIT_JR);
    assign push                 = in_valid && in_ready;
    assign head                 = sic_packet_t'(fifo_dout);
    assign sic_packet_out       = pkt_q;
    assign fetch_redirect_valid = fr_valid;
    assign fetch_redirect_pc    = fr_pc;
    assign jr_stall             = (state == ST_WAIT_JR);

    pkt_fifo #(
        .WIDTH (PW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (PW'(in_pkt)),
        .pop   (pop),
        .dout  (fifo_dout),
        .flush (flush),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Round-robin pick: first requesting SIC at or after the rr pointer.
    always_comb begin
        req_found = 1'b0;
        req_sel   = '0;
        idx       = 0;
        for (int i = 0; i < NUM_SIC; i++) begin
            idx = (int'(rr) + i) % NUM_SIC;
            if (!req_found && sic_req_instr[idx]) begin
                req_found = 1'b1;
                req_sel   = SW'(idx);
            end
        end
    end

    // Redirect match against the outstanding JR id; lowest SIC index wins.
    always_comb begin
        rd_match = 1'b0;
        rd_pc    = '0;
        for (int k = 0; k < NUM_SIC; k++) begin
            if (!rd_match && sic_redirect_valid[k] &&
                sic_redirect_issue_id[k*ID_WIDTH +: ID_WIDTH] == offer_id) begin
                rd_match = 1'b1;
                rd_pc    = sic_redirect_pc[k*32 +: 32];
            end
        end
    end

    // Next-state and datapath: offer creation, acceptance, JR wait.
    always_comb begin
        state_d    = state;
        tgt_d      = tgt;
        rr_d       = rr;
        cnt_d      = cnt;
        offer_id_d = offer_id;
        pkt_d      = pkt_q;
        fr_valid_d = 1'b0;
        fr_pc_d    = fr_pc;
        pop        = 1'b0;
        flush      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && req_found) begin
                    pkt_d[req_sel]          = head;
                    pkt_d[req_sel].valid    = 1'b1;
                    pkt_d[req_sel].issue_id = SIC_ID_WIDTH'(cnt);
                    offer_id_d              = cnt;
                    tgt_d                   = req_sel;
                    cnt_d                   = cnt + 1'b1;
                    pop                     = 1'b1;
                    state_d                 = ST_OFFER;
                end
            end
            ST_OFFER: begin
                // A SIC latches by dropping its request while the offer is up.
                if (pkt_q[tgt].valid && !sic_req_instr[tgt]) begin
                    pkt_d[tgt].valid = 1'b0;
                    rr_d    = (tgt == SW'(NUM_SIC - 1)) ? '0 : tgt + 1'b1;
                    state_d = is_jr(pkt_q[tgt]) ? ST_WAIT_JR : ST_IDLE;
                end
            end
            ST_WAIT_JR: begin
                if (rd_match) begin
                    fr_valid_d = 1'b1;
                    fr_pc_d    = rd_pc;
                    flush      = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset drops any outstanding offer immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tgt      <= '0;
            rr       <= '0;
            cnt      <= '0;
            offer_id <= '0;
            pkt_q    <= '0;
            fr_valid <= 1'b0;
            fr_pc    <= '0;
        end else begin
            state    <= state_d;
            tgt      <= tgt_d;
            rr       <= rr_d;
            cnt      <= cnt_d;
            offer_id <= offer_id_d;
            pkt_q    <= pkt_d;
            fr_valid <= fr_valid_d;
            fr_pc    <= fr_pc_d;
        end
    end

endmodule
